// File: rtl/gpu_pkg.sv
// Shared definitions for the chad GPU: op codes, FSM states, channel width helper.
package gpu_pkg;

  localparam logic [2:0] OP_SETCOL = 3'd0;
  localparam logic [2:0] OP_SETPAT = 3'd1;
  localparam logic [2:0] OP_MONO   = 3'd2;
  localparam logic [2:0] OP_GRAY   = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL
  } state_e;

  // Per-channel width of an RGB pixel packed into 'width' bits.
  function automatic int unsigned chan_width(input int unsigned width);
    return width / 3;
  endfunction

endpackage

// File: rtl/gpu_blend_ch.sv
// One colour channel of the GRAY blend: fg*wf + bg*wb by MSB-first shift-add.
module gpu_blend_ch #(
  parameter int unsigned CW = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [CW-1:0] fg_i,
  input  logic [CW-1:0] bg_i,
  input  logic [CW:0]   wf_i,
  input  logic [CW:0]   wb_i,
  output logic [CW-1:0] res_o
);

  localparam int unsigned ACCW = 2 * CW + 1;

  logic [ACCW-1:0] acc_q, acc_d;
  logic [CW:0]     wf_q, wf_d;
  logic [CW:0]     wb_q, wb_d;

  // Load clears the accumulator and latches both weights; each step consumes one weight MSB.
  always_comb begin
    acc_d = acc_q;
    wf_d  = wf_q;
    wb_d  = wb_q;
    if (load_i) begin
      acc_d = '0;
      wf_d  = wf_i;
      wb_d  = wb_i;
    end else if (step_i) begin
      acc_d = (acc_q << 1)
            + (wf_q[CW] ? ACCW'(fg_i) : '0)
            + (wb_q[CW] ? ACCW'(bg_i) : '0);
      wf_d  = wf_q << 1;
      wb_d  = wb_q << 1;
    end
  end

  // Result is taken from the next-state value so the top can capture it on the final step edge.
  assign res_o = CW'(acc_d >> CW);

  // Accumulator and weight shift registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      wf_q  <= '0;
      wb_q  <= '0;
    end else begin
      acc_q <= acc_d;
      wf_q  <= wf_d;
      wb_q  <= wb_d;
    end
  end

endmodule

// File: rtl/chad_gpu.sv
// chad GPU: colour/pattern registers, MONO pattern expansion and GRAY blend sequencing.
module chad_gpu
  import gpu_pkg::*;
#(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sel,
  input  logic             go,
  output logic             busy,
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b
);

  localparam int unsigned CW   = chan_width(WIDTH);
  localparam int unsigned CNTW = $clog2(CW + 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] fg_q, fg_d;
  logic [WIDTH-1:0] bg_q, bg_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             blend_load;
  logic             blend_step;
  logic [CW:0]      wf;
  logic [CW:0]      wb;
  logic [WIDTH-1:0] blend_y;

  // Blend weights: w+1 for foreground, 2^CW-(w+1) for background.
  assign wf = {1'b0, a[CW-1:0]} + (CW+1)'(1);
  assign wb = {1'b1, {CW{1'b0}}} - wf;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    gpu_blend_ch #(.CW(CW)) u_blend (
      .clk_i  (clk),
      .rst_i  (rst),
      .load_i (blend_load),
      .step_i (blend_step),
      .fg_i   (fg_q[c*CW +: CW]),
      .bg_i   (bg_q[c*CW +: CW]),
      .wf_i   (wf),
      .wb_i   (wb),
      .res_o  (blend_y[c*CW +: CW])
    );
  end

  // Next-state, operand capture and register updates for all ops.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    pat_d      = pat_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    blend_load = 1'b0;
    blend_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          op_d = sel;
          a_d  = a;
          b_d  = b;
          if (sel == OP_GRAY) begin
            blend_load = 1'b1;
            cnt_d      = '0;
            state_d    = ST_MUL;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        case (op_q)
          OP_SETCOL: begin
            fg_d = a_q;
            bg_d = b_q;
          end
          OP_SETPAT: pat_d = a_q;
          OP_MONO: begin
            y_d   = pat_q[WIDTH-1] ? fg_q : bg_q;
            pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
          end
          default: ;
        endcase
      end
      ST_MUL: begin
        blend_step = 1'b1;
        cnt_d      = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(CW)) begin
          y_d     = blend_y;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
      pat_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      pat_q   <= pat_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign y    = y_q;

endmodule

// File: tb/tb_chad_gpu.sv
// Directed bench for chad_gpu at default width with hand-computed pixels.
module tb_chad_gpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sel = '0;
  logic        go  = 1'b0;
  logic        busy;
  logic [17:0] y;
  logic [17:0] a = '0;
  logic [17:0] b = '0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  localparam logic [17:0] FG = 18'o777371;
  localparam logic [17:0] BG = 18'o001116;

  chad_gpu #(.WIDTH(18)) dut (
    .clk  (clk),
    .rst  (rst),
    .sel  (sel),
    .go   (go),
    .busy (busy),
    .y    (y),
    .a    (a),
    .b    (b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  // Issue one command, scramble operands afterwards, and measure busy cycles.
  task automatic run_op(input logic [2:0] s, input logic [17:0] av, input logic [17:0] bv,
                        input int unsigned exp_lat, input string tag);
    int unsigned lat = 0;
    @(negedge clk);
    sel = s; a = av; b = bv; go = 1'b1;
    @(negedge clk);
    go = 1'b0; a = 18'o525252; b = 18'o252525; sel = 3'd7;
    while (busy && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  logic [17:0] pat_seq;
  logic [17:0] mono_exp;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    rst = 1'b0;

    run_op(3'd0, FG, BG, 1, "setcol");
    check("setcol_y", 32'(y), 32'd0);

    // MONO sequence and wrap
    pat_seq = 18'o520252;
    run_op(3'd1, pat_seq, 18'o0, 1, "setpat");
    check("setpat_y", 32'(y), 32'd0);
    for (int unsigned i = 0; i < 19; i++) begin
      run_op(3'd2, 18'o0, 18'o0, 1, "mono");
      mono_exp = pat_seq[17 - (i % 18)] ? FG : BG;
      check($sformatf("mono%0d_y", i), 32'(y), 32'(mono_exp));
    end

    // GRAY blends
    run_op(3'd3, 18'o26, 18'o0, 7, "gray26");
    check("gray26_y", 32'(y), 32'(18'o263235));
    run_op(3'd3, 18'o77, 18'o0, 7, "gray77");
    check("gray77_y", 32'(y), 32'(FG));
    run_op(3'd3, 18'o00, 18'o0, 7, "gray00");
    check("gray00_y", 32'(y), 32'(18'o001116));

    // go pulses during GRAY must be ignored
    @(negedge clk);
    sel = 3'd3; a = 18'o26; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    sel = 3'd0; a = 18'o123456; b = 18'o654321; go = 1'b1;
    @(negedge clk);
    sel = 3'd2; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int unsigned k = 0; k < 20 && busy; k++) @(negedge clk);
    check("midgo_busy", 32'(busy), 32'd0);
    check("midgo_y", 32'(y), 32'(18'o263235));

    // Reserved op leaves everything unchanged
    run_op(3'd5, 18'o111111, 18'o222222, 1, "rsvd");
    check("rsvd_y", 32'(y), 32'(18'o263235));
    run_op(3'd2, 18'o0, 18'o0, 1, "rsvd_pat1");
    check("rsvd_pat1_y", 32'(y), 32'(BG));
    run_op(3'd2, 18'o0, 18'o0, 1, "rsvd_pat2");
    check("rsvd_pat2_y", 32'(y), 32'(FG));
    run_op(3'd3, 18'o77, 18'o0, 7, "rsvd_fg");
    check("rsvd_fg_y", 32'(y), 32'(FG));

    // Reset during GRAY aborts with no partial update
    @(negedge clk);
    sel = 3'd3; a = 18'o26; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_y", 32'(y), 32'd0);
    repeat (8) @(negedge clk);
    check("rstmid_y_late", 32'(y), 32'd0);
    run_op(3'd3, 18'o77, 18'o0, 7, "rstmid_fg");
    check("rstmid_fg_y", 32'(y), 32'd0);

    // Simultaneous go and rst: reset wins
    @(negedge clk);
    rst = 1'b1; sel = 3'd0; a = FG; b = BG; go = 1'b1;
    @(negedge clk);
    rst = 1'b0; go = 1'b0;
    check("rstgo_busy", 32'(busy), 32'd0);
    run_op(3'd3, 18'o00, 18'o0, 7, "rstgo_gray");
    check("rstgo_y", 32'(y), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
